pll_drp_reconfig: RTL
=====================

// Module: pll_drp_reconfig
// PURPOSE
//  Runtime reconfiguration controller for a 7-series PLLE2/MMCME2 through its DRP port.
//  Selects one of NUM_MODES register sets (e.g. 720p/1080p pixel clocks) and reprograms them.
//  For each register it does read-modify-write, holding the PLL in reset, then waits for lock.
//  Sits beside the clocking primitive in the top level; driven by a CSR or by the video mode logic.
// PARAMETERS
//  NUM_MODES      2      number of selectable register sets (>=1)
//  NUM_REGS       8      DRP registers rewritten per mode (>=1)
//  DRDY_TIMEOUT   64     max cycles waiting for drp_rdy_i per access
//  LOCK_TIMEOUT   65536  max cycles waiting for lock after reset release
//  INIT_LOAD      1      1: automatically load DEFAULT_MODE after rst_i
//  DEFAULT_MODE   0      mode loaded by INIT_LOAD
// PORTS
//  clk_i          in   1   DRP clock; all logic in this domain
//  rst_i          in   1   synchronous, active-high reset
//  start_i        in   1   1-cycle request to load mode_i; ignored while busy_o=1
//  mode_i         in   MW  mode index, MW=max(1,$clog2(NUM_MODES))
//  table_i        in   NUM_MODES*NUM_REGS*40  static table; entry (m,e) at [(m*NUM_REGS+e)*40 +: 40]
//                          = {addr[39:32] (bits 38:32 used), keep_mask[31:16], data[15:0]}
//  drp_en_o       out  1   DRP enable strobe
//  drp_we_o       out  1   DRP write enable (valid with drp_en_o)
//  drp_addr_o     out  7   DRP address
//  drp_di_o       out  16  DRP write data
//  drp_do_i       in   16  DRP read data (valid with drp_rdy_i)
//  drp_rdy_i      in   1   DRP access complete
//  pll_rst_o      out  1   PLL RST pin
//  pll_locked_i   in   1   PLL LOCKED (asynchronous; synchronised internally, 2 flops)
//  busy_o         out  1   sequence in progress
//  done_o         out  1   1-cycle pulse: sequence finished (success or error)
//  error_o        out  1   sticky: last sequence failed; cleared on accepted start
//  locked_o       out  1   synchronised lock AND !busy_o AND !error_o
// BEHAVIOUR
//  Reset values: all outputs 0, drp_addr_o/drp_di_o 0, state IDLE, sync flops 0.
//  States: IDLE, RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT.
//  IDLE: start_i=1 (or first cycle after rst_i if INIT_LOAD, mode=DEFAULT_MODE) latches mode.
//    Latched mode>=NUM_MODES: no DRP access; next cycle done_o=1, error_o=1, stays IDLE.
//    Otherwise: error_o<=0, busy_o<=1, entry index e<=0 -> RST_ASSERT.
//  RST_ASSERT: pll_rst_o<=1 (held until RELEASE) -> RD.
//  RD: drp_en_o=1, drp_we_o=0, drp_addr_o=entry addr for exactly 1 cycle -> RD_WAIT.
//  RD_WAIT: on drp_rdy_i capture wr=(drp_do_i & keep_mask) | (data & ~keep_mask) -> WR.
//  WR: drp_en_o=1, drp_we_o=1, drp_di_o=wr for 1 cycle -> WR_WAIT.
//  WR_WAIT: on drp_rdy_i: e==NUM_REGS-1 -> RELEASE, else e<=e+1 -> RD.
//  Wait states count cycles from 0; count reaching DRDY_TIMEOUT without rdy -> abort:
//    pll_rst_o<=0, error_o<=1, done_o pulse, -> IDLE. drp_rdy_i outside wait states ignored.
//  RELEASE: pll_rst_o<=0, lock counter cleared -> LOCK_WAIT.
//  LOCK_WAIT: synced lock=1 -> done_o pulse, busy_o<=0, -> IDLE (error_o=0).
//    counter reaching LOCK_TIMEOUT -> done_o, error_o<=1, -> IDLE.
//  drp_en_o never asserted while a previous access is outstanding; at most one per access.
//  start_i during busy_o=1 dropped (not queued). done_o and new start same cycle: start ignored.
//  rst_i mid-sequence: immediate return to reset values (pll_rst_o=0); PLL registers may be
//    partially written; INIT_LOAD re-programs DEFAULT_MODE, else a new start_i is required.
//  Latency with 1-cycle DRP response: 2 + 4*NUM_REGS + 1 cycles to RELEASE, then lock time.
//  table_i must be stable while busy_o=1.
// TESTING
//  1 DRP model rdy 3 cycles after en, rd 0x1234, keep 0xF000, data 0x0567 -> write 0x1567.
//  2 NUM_REGS=8, start mode 1 -> 8 reads+8 writes to table addrs in order; pll_rst_o spans all;
//    lock after 100 cycles -> done_o pulse, locked_o=1, error_o=0.
//  3 model never asserts rdy -> after DRDY_TIMEOUT cycles done_o, error_o=1, pll_rst_o=0.
//  4 mode_i=NUM_MODES (out of range) -> no drp_en_o, done_o next cycle, error_o=1.
//  5 start_i pulsed while busy -> ignored, single sequence; lock held 0 -> error at LOCK_TIMEOUT.
//  6 rst_i mid-write with INIT_LOAD=1 -> outputs reset, DEFAULT_MODE sequence restarts.

Source files
------------

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration controller for a 7-series PLLE2/MMCME2: holds the PLL in reset,
// read-modify-writes one table of DRP registers per mode, then waits for lock.
module pll_drp_reconfig #(
    parameter int NUM_MODES    = 2,
    parameter int NUM_REGS     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int INIT_LOAD    = 1,
    parameter int DEFAULT_MODE = 0,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [MW-1:0]                   mode_i,
    input  logic [NUM_MODES*NUM_REGS*40-1:0] table_i,
    output logic                            drp_en_o,
    output logic                            drp_we_o,
    output logic [6:0]                      drp_addr_o,
    output logic [15:0]                     drp_di_o,
    input  logic [15:0]                     drp_do_i,
    input  logic                            drp_rdy_i,
    output logic                            pll_rst_o,
    input  logic                            pll_locked_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic                            locked_o,
    output logic [2:0]                      dbg_state_o
);

    localparam int EW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [EW-1:0] LAST_E    = EW'(NUM_REGS - 1);
    localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [MW-1:0] DEF_MODE  = MW'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RST_ASSERT = 3'd1,
        RD         = 3'd2,
        RD_WAIT    = 3'd3,
        WR         = 3'd4,
        WR_WAIT    = 3'd5,
        RELEASE    = 3'd6,
        LOCK_WAIT  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] mode_q, mode_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   di_q, di_d;
    logic          pll_rst_q, pll_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          init_q, init_d;
    logic          meta_q, meta_d;
    logic          sync_q, sync_d;

    logic [MW-1:0] sel_mode;
    logic [MW-1:0] mode_safe;
    logic [EW-1:0] entry_nxt;
    logic [39:0]   cur_ent;
    logic [39:0]   nxt_ent;
    logic [15:0]   wr_val;
    logic          abort;

    // Table lookups for the current entry and the one after it; mode is clamped so an
    // out-of-range latched mode never indexes past the table.
    assign sel_mode  = init_q ? DEF_MODE : mode_i;
    assign mode_safe = (int'(mode_q) < NUM_MODES) ? mode_q : '0;
    assign entry_nxt = (entry_q == LAST_E) ? entry_q : entry_q + EW'(1);
    assign cur_ent   = table_i[(int'(mode_safe) * NUM_REGS + int'(entry_q)) * 40 +: 40];
    assign nxt_ent   = table_i[(int'(mode_safe) * NUM_REGS + int'(entry_nxt)) * 40 +: 40];
    assign wr_val    = (drp_do_i & cur_ent[31:16]) | (cur_ent[15:0] & ~cur_ent[31:16]);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        di_d      = di_q;
        pll_rst_d = pll_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        init_d    = init_q;
        meta_d    = pll_locked_i;
        sync_d    = meta_q;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start arriving in the same cycle as the done pulse is dropped.
                if (!done_q && (start_i || init_q)) begin
                    init_d = 1'b0;
                    mode_d = sel_mode;
                    if (int'(sel_mode) >= NUM_MODES) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        entry_d = '0;
                        state_d = RST_ASSERT;
                    end
                end
            end
            RST_ASSERT: begin
                pll_rst_d = 1'b1;
                addr_d    = cur_ent[38:32];
                state_d   = RD;
            end
            RD: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_rdy_i) begin
                    di_d    = wr_val;
                    state_d = WR;
                end else if (cnt_q == DRDY_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR: begin
                cnt_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (drp_rdy_i) begin
                    if (entry_q == LAST_E) begin
                        state_d = RELEASE;
                    end else begin
                        entry_d = entry_nxt;
                        addr_d  = nxt_ent[38:32];
                        state_d = RD;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                pll_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = LOCK_WAIT;
            end
            LOCK_WAIT: begin
                if (sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A DRP access that never completes releases the PLL and ends the sequence.
        if (abort) begin
            pll_rst_d = 1'b0;
            error_d   = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            entry_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            di_q      <= '0;
            pll_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            init_q    <= (INIT_LOAD != 0);
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            di_q      <= di_d;
            pll_rst_q <= pll_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            init_q    <= init_d;
            meta_q    <= meta_d;
            sync_q    <= sync_d;
        end
    end

    assign drp_en_o    = (state_q == RD) || (state_q == WR);
    assign drp_we_o    = (state_q == WR);
    assign drp_addr_o  = addr_q;
    assign drp_di_o    = di_q;
    assign pll_rst_o   = pll_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign locked_o    = sync_q & ~busy_q & ~error_q;
    assign dbg_state_o = state_q;

endmodule
